// File: rtl/simon_param_cipher_core.sv
// rtl/simon_param_cipher_core.sv - SIMON32/64 core with selectable rounds per clock and valid/ready handshakes

// One step of the SIMON32/64 key expansion: produces rk[i+4] from rk[i..i+3].
module key_schedule #(
  parameter logic Z = 1'b0  // bit i of the z0 constant sequence
) (
  input  logic [63:0] kin_i,   // {rk[i+3], rk[i+2], rk[i+1], rk[i]}
  output logic [15:0] knext_o  // rk[i+4]
);
  logic [15:0] k0, k1, k3;
  logic [15:0] t0, t1;
  logic        unused_k2;

  assign k0 = kin_i[15:0];
  assign k1 = kin_i[31:16];
  assign k3 = kin_i[63:48];
  // With four key words the third word does not take part in the recurrence.
  assign unused_k2 = ^kin_i[47:32];

  assign t0 = {k3[2:0], k3[15:3]} ^ k1;
  assign t1 = t0 ^ {t0[0], t0[15:1]};
  // ~k0 ^ 3 is the round constant 0xfffc folded into k0.
  assign knext_o = ~k0 ^ t1 ^ {15'd0, Z} ^ 16'd3;
endmodule

module simon_param_cipher_core #(
  parameter int UNROLL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [31:0] text_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] text_out,
  output logic        busy
);
  localparam int         N     = 32 / UNROLL;
  localparam int         SEL_W = 16 * UNROLL;
  localparam logic [4:0] LAST  = 5'(N - 1);
  // First 28 bits of the z0 sequence; bit i feeds the key-schedule step that makes rk[i+4].
  localparam logic [0:27] Z0 = 28'b1111101000100101011000011100;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 &&
      UNROLL != 16 && UNROLL != 32) begin : g_bad_unroll
    $error("simon_param_cipher_core: UNROLL must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e        fsm_q;
  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [63:0] kreg_q;
  logic [4:0]  cnt_q;
  logic        mode_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [511:0]     rk_flat;
  logic [SEL_W-1:0] rk_enc_sel;
  logic [SEL_W-1:0] rk_dec_sel;
  logic [8:0]       enc_base;
  logic [8:0]       dec_base;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign text_out  = state_q;

  // Round keys: first four straight from the latched key, the rest by chained expansion.
  for (genvar i = 0; i < 32; i++) begin : g_rk
    logic [15:0] w;
    if (i < 4) begin : g_seed
      assign w = kreg_q[16*i +: 16];
    end else begin : g_exp
      key_schedule #(.Z(Z0[i-4])) u_ks (
        .kin_i   ({g_rk[i-1].w, g_rk[i-2].w, g_rk[i-3].w, g_rk[i-4].w}),
        .knext_o (w)
      );
    end
    assign rk_flat[16*i +: 16] = w;
  end

  // Pick this cycle's UNROLL keys: ascending block for encrypt, mirrored block for decrypt.
  always_comb begin
    enc_base   = 9'(int'(cnt_q) * SEL_W);
    dec_base   = 9'(int'(LAST - cnt_q) * SEL_W);
    rk_enc_sel = rk_flat[enc_base +: SEL_W];
    rk_dec_sel = rk_flat[dec_base +: SEL_W];
  end

  function automatic logic [15:0] f_fn(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  // UNROLL chained rounds; decrypt walks its key block from the top down.
  always_comb begin
    logic [15:0] x_v;
    logic [15:0] y_v;
    logic [15:0] t_v;
    x_v = state_q[31:16];
    y_v = state_q[15:0];
    t_v = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (mode_q) begin
        t_v = y_v;
        y_v = x_v ^ f_fn(y_v) ^ rk_dec_sel[16*(UNROLL-1-u) +: 16];
        x_v = t_v;
      end else begin
        t_v = x_v;
        x_v = y_v ^ f_fn(x_v) ^ rk_enc_sel[16*u +: 16];
        y_v = t_v;
      end
    end
    state_d = {x_v, y_v};
  end

  // Block sequencer: accept in IDLE, N round cycles in RUN, hold result in DONE until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      kreg_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            kreg_q     <= key;
            state_q    <= text_in;
            mode_q     <= decrypt;
            cnt_q      <= '0;
            fsm_q      <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          state_q <= state_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            fsm_q       <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm_q       <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q       <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule
